fifo_stream_reader: RTL

- Client-side read engine for the team's FIFO interface: it drives ren, and samples dout and empty from the FIFO server.
- Converts FIFO reads into a valid/ready output stream, with a 2-entry output buffer that absorbs the one-cycle FIFO read latency.
- Sustains one word per cycle when the consumer is always ready.
- Sits between any FIFO server instance and a downstream stream consumer. It also provides an enable/idle control pair and a handshake counter for monitors.

---
 rtl/fifo_stream_reader.sv | 117 +++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: client-side read engine for the FIFO interface.
// It issues ren, captures dout one cycle later into a 2-entry buffer, and
// presents the buffer head as a first-word-fall-through valid/ready stream.
// An enable/idle pair controls fetching. A wrapping counter tracks
// completed handshakes.
module fifo_stream_reader #(
    parameter int dw = 32,
    parameter int cw = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [dw-1:0] dout,
    input  logic          empty,
    output logic          ren,
    input  logic          en,
    output logic [dw-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          idle,
    output logic [cw-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    occ_q, occ_d;            // buffer occupancy, 0..2
    logic          inflight_q, inflight_d;  // ren was issued last cycle
    logic [dw-1:0] buf0_q, buf0_d;          // head slot
    logic [dw-1:0] buf1_q, buf1_d;          // second slot
    logic          idle_q, idle_d;
    logic [cw-1:0] xfer_cnt_q, xfer_cnt_d;

    logic          fetch;
    logic          pop;
    logic [2:0]    pending;   // words held after this cycle's capture and pop
    logic [1:0]    tail_idx;  // slot written by an arriving word

    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = buf0_q;
    assign idle     = idle_q;
    assign xfer_cnt = xfer_cnt_q;

    assign fetch    = (state_q == S_RUN);
    assign pop      = m_valid & m_ready;
    // The arriving in-flight word counts against capacity in the same cycle.
    assign pending  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign tail_idx = occ_q - {1'b0, pop};
    assign ren      = fetch & ~empty & (pending < 3'd2);

    // Next-state logic: en has priority over drain completion.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (en) state_d = S_RUN;
            S_RUN:   if (!en) state_d = S_DRAIN;
            S_DRAIN: begin
                if (en) begin
                    state_d = S_RUN;
                end else if (!inflight_q && (occ_q == 2'd0)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        idle_d = (state_d == S_IDLE);
    end

    // Buffer, occupancy and handshake counter update.
    always_comb begin
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        occ_d      = pending[1:0];
        inflight_d = ren;
        xfer_cnt_d = xfer_cnt_q + {{(cw-1){1'b0}}, pop};
        // A pop shifts the second slot into the head.
        if (pop) begin
            buf0_d = buf1_q;
        end
        // The returning word lands behind whatever survives this cycle's pop.
        if (inflight_q) begin
            if (tail_idx == 2'd0) begin
                buf0_d = dout;
            end else begin
                buf1_d = dout;
            end
        end
    end

    // State registers with asynchronous reset; reset discards buffered and in-flight words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            // NOTE: the data slots are reset because the head slot drives m_data directly.
            buf0_q     <= '0;
            buf1_q     <= '0;
            idle_q     <= 1'b1;
            xfer_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            idle_q     <= idle_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

endmodule
